hazard_scoreboard: RTL

//  Parametrised hazard unit for the in-order pipeline. Tracks its own shadow pipeline of in-flight

---
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-hazard-unit bundle: the instruction presented in decode plus the stall/forwarding results.
interface hazard_scoreboard_if #(
    parameter int RA_W       = 5,
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic             flush;
    logic             dec_valid;
    logic [RA_W-1:0]  dec_rs_a;
    logic [RA_W-1:0]  dec_rs_b;
    logic             dec_uses_a;
    logic             dec_uses_b;
    logic             dec_writes;
    logic [RA_W-1:0]  dec_rd;
    logic             dec_is_load;
    logic             stall;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output flush, dec_valid, dec_rs_a, dec_rs_b, dec_uses_a, dec_uses_b,
               dec_writes, dec_rd, dec_is_load,
        input  stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  flush, dec_valid, dec_rs_a, dec_rs_b, dec_uses_a, dec_uses_b,
               dec_writes, dec_rd, dec_is_load,
        output stall, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: shadow pipe of in-flight destinations, load-use stall, forwarding selects.
// stall is combinational in the decode cycle; fwd_a/fwd_b register one cycle later (valid while consumer is in EX).
module hazard_scoreboard #(
    parameter int RA_W       = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic [FWD_STAGES:1] v_q, v_d;
    logic [FWD_STAGES:1] ld_q, ld_d;
    logic [RA_W-1:0]     rd_q [FWD_STAGES:1];
    logic [RA_W-1:0]     rd_d [FWD_STAGES:1];
    logic [SEL_W-1:0]    fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0]    fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0]    sel_a, sel_b;
    logic                hz_a, hz_b;
    logic                stall;

    // Scan oldest to youngest so the nearest producer overwrites any older match.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hz_a  = 1'b0;
        hz_b  = 1'b0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (bus.dec_uses_a && (bus.dec_rs_a != '0) && v_q[k] && (rd_q[k] == bus.dec_rs_a)) begin
                sel_a = SEL_W'(k);
                hz_a  = ld_q[k] && (k < LOAD_READY);
            end
            if (bus.dec_uses_b && (bus.dec_rs_b != '0) && v_q[k] && (rd_q[k] == bus.dec_rs_b)) begin
                sel_b = SEL_W'(k);
                hz_b  = ld_q[k] && (k < LOAD_READY);
            end
        end
    end

    assign stall = bus.dec_valid && !bus.flush && (hz_a || hz_b);

    always_comb begin
        v_d     = v_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            v_d     = '0;
            fwd_a_d = '0;
            fwd_b_d = '0;
        end else begin
            for (int k = FWD_STAGES; k >= 2; k--) begin
                v_d[k]  = v_q[k-1];
                ld_d[k] = ld_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
            // A stalled instruction stays in decode, so EX receives a bubble.
            v_d[1]  = bus.dec_valid && bus.dec_writes && (bus.dec_rd != '0) && !stall;
            ld_d[1] = bus.dec_is_load;
            rd_d[1] = bus.dec_rd;
            fwd_a_d = (bus.dec_valid && !stall) ? sel_a : '0;
            fwd_b_d = (bus.dec_valid && !stall) ? sel_b : '0;
        end
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q     <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            v_q     <= v_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload is qualified by v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

    assign bus.stall     = stall;
    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.stall_cnt = cnt_q;
endmodule
